// File: rtl/gc_sync_fifo_pkg.sv
// Shared helpers for the Gray-pointer FIFO family: binary/Gray conversion on a
// wide container, truncated or zero-extended by callers to their pointer width.
package gc_fifo_pkg;

  localparam int GC_MAX_W = 32;

  function automatic logic [GC_MAX_W-1:0] bin2gray(input logic [GC_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Kept for the pointer checker and the dual-clock variant that resolves
  // synchronised Gray pointers back into binary.
  function automatic logic [GC_MAX_W-1:0] gray2bin(input logic [GC_MAX_W-1:0] gray);
    logic [GC_MAX_W-1:0] bin;
    bin[GC_MAX_W-1] = gray[GC_MAX_W-1];
    for (int i = GC_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gc_sync_fifo_ptr.sv
// Binary pointer with a registered Gray copy; both advance on the same edge so
// the Gray value never shows more than one toggling bit per increment.
module gc_ptr
  import gc_fifo_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         inc,
  output logic [W-1:0] bin,
  output logic [W-1:0] gray
);

  logic [W-1:0] bin_next;

  assign bin_next = bin + W'(1);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      bin  <= '0;
      gray <= '0;
    end else if (inc) begin
      bin  <= bin_next;
      gray <= W'(bin2gray(GC_MAX_W'(bin_next)));
    end
  end

endmodule

// File: rtl/gc_sync_fifo.sv
// Single-clock FIFO built around Gray-coded pointers; full/empty come from the
// Gray compare so the same logic carries over to a dual-clock version.
module gc_sync_fifo
  import gc_fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 3,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              wrEn,
  input  logic [DATA_W-1:0] wrData,
  input  logic              rdEn,
  output logic [DATA_W-1:0] rdData,
  output logic              full,
  output logic              empty,
  output logic              almostFull,
  output logic              almostEmpty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  output logic [ADDR_W:0]   wrPtrGray,
  output logic [ADDR_W:0]   rdPtrGray
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] AFULL_LVL  = PTR_W'(AFULL_TH);
  localparam logic [PTR_W-1:0] AEMPTY_LVL = PTR_W'(AEMPTY_TH);

  logic [PTR_W-1:0]  wr_bin;
  logic [PTR_W-1:0]  rd_bin;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] mem [DEPTH];

  assign wr_acc = wrEn & ~full;
  assign rd_acc = rdEn & ~empty;

  gc_ptr #(.W(PTR_W)) u_wr_ptr (
    .clk  (clk),
    .rstN (rstN),
    .inc  (wr_acc),
    .bin  (wr_bin),
    .gray (wrPtrGray)
  );

  gc_ptr #(.W(PTR_W)) u_rd_ptr (
    .clk  (clk),
    .rstN (rstN),
    .inc  (rd_acc),
    .bin  (rd_bin),
    .gray (rdPtrGray)
  );

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_bin[ADDR_W-1:0]] <= wrData;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rdData    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wrEn & full;
      underflow <= rdEn & empty;
      if (rd_acc) begin
        rdData <= mem[rd_bin[ADDR_W-1:0]];
      end
    end
  end

  // Full means the writer is exactly one lap ahead: in Gray that shows up as
  // the two top bits inverted and everything below identical.
  assign full  = (wrPtrGray[PTR_W-1:PTR_W-2] == ~rdPtrGray[PTR_W-1:PTR_W-2]) &&
                 (wrPtrGray[PTR_W-3:0] == rdPtrGray[PTR_W-3:0]);
  assign empty = (wrPtrGray == rdPtrGray);

  assign count       = wr_bin - rd_bin;
  assign almostFull  = (count >= AFULL_LVL);
  assign almostEmpty = (count <= AEMPTY_LVL);

endmodule

// File: tb/tb_gc_sync_fifo.sv
// Directed and scoreboard-checked bench for gc_sync_fifo with the default
// 8-bit x 8-deep configuration.
module tb_gc_sync_fifo;
  import gc_fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rstN;
  logic       wrEn;
  logic [7:0] wrData;
  logic       rdEn;
  logic [7:0] rdData;
  logic       full, empty, almostFull, almostEmpty, overflow, underflow;
  logic [3:0] count, wrPtrGray, rdPtrGray;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  int         m_wr, m_rd;
  logic [7:0] m_data;
  logic       m_ovf, m_udf;

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       rd;
    logic [7:0] exp_rd;
    logic [3:0] exp_cnt;
    logic [5:0] exp_flags;
  } vec_t;

  vec_t vecs[20];

  gc_sync_fifo #(.DATA_W(8), .ADDR_W(3), .AFULL_TH(6), .AEMPTY_TH(2)) dut (
    .clk         (clk),
    .rstN        (rstN),
    .wrEn        (wrEn),
    .wrData      (wrData),
    .rdEn        (rdEn),
    .rdData      (rdData),
    .full        (full),
    .empty       (empty),
    .almostFull  (almostFull),
    .almostEmpty (almostEmpty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .wrPtrGray   (wrPtrGray),
    .rdPtrGray   (rdPtrGray)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] flagsNow();
    return {full, empty, almostFull, almostEmpty, overflow, underflow};
  endfunction

  task automatic modelReset();
    exp_q.delete();
    m_wr   = 0;
    m_rd   = 0;
    m_data = 8'h00;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  task automatic doReset();
    rstN   = 1'b0;
    wrEn   = 1'b0;
    rdEn   = 1'b0;
    wrData = 8'h00;
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    modelReset();
  endtask

  // One clock of stimulus; expectations come from the queue model's pre-edge state.
  task automatic applyStimulus(input logic wr, input logic [7:0] d, input logic rd);
    logic        full_m, empty_m, wr_inc, rd_inc;
    logic [31:0] prev_wg, prev_rg;
    logic [5:0]  ef;
    full_m  = (exp_q.size() == 8);
    empty_m = (exp_q.size() == 0);
    prev_wg = bin2gray(32'(m_wr));
    prev_rg = bin2gray(32'(m_rd));
    wrEn   = wr;
    wrData = d;
    rdEn   = rd;
    @(posedge clk);
    #1;
    wrEn = 1'b0;
    rdEn = 1'b0;
    m_ovf  = wr & full_m;
    m_udf  = rd & empty_m;
    wr_inc = wr & ~full_m;
    rd_inc = rd & ~empty_m;
    if (rd_inc) begin
      m_data = exp_q.pop_front();
      m_rd   = (m_rd + 1) % 16;
    end
    if (wr_inc) begin
      exp_q.push_back(d);
      m_wr = (m_wr + 1) % 16;
    end
    ef = {exp_q.size() == 8, exp_q.size() == 0, exp_q.size() >= 6,
          exp_q.size() <= 2, m_ovf, m_udf};
    checkOutput("m_rdData", 32'(rdData), 32'(m_data));
    checkOutput("m_count", 32'(count), 32'(exp_q.size()));
    checkOutput("m_flags", 32'(flagsNow()), 32'(ef));
    checkOutput("m_wrGray", 32'(wrPtrGray), bin2gray(32'(m_wr)));
    checkOutput("m_rdGray", 32'(rdPtrGray), bin2gray(32'(m_rd)));
    checkOutput("m_wrGrayStep", 32'($countones(32'(wrPtrGray) ^ prev_wg)), 32'(wr_inc));
    checkOutput("m_rdGrayStep", 32'($countones(32'(rdPtrGray) ^ prev_rg)), 32'(rd_inc));
  endtask

  initial begin
    // flags = {full, empty, almostFull, almostEmpty, overflow, underflow}
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 6'b010100};
    vecs[1]  = '{1'b1, 8'h11, 1'b0, 8'h00, 4'd1, 6'b000100};
    vecs[2]  = '{1'b1, 8'h22, 1'b0, 8'h00, 4'd2, 6'b000100};
    vecs[3]  = '{1'b1, 8'h33, 1'b0, 8'h00, 4'd3, 6'b000000};
    vecs[4]  = '{1'b1, 8'h44, 1'b0, 8'h00, 4'd4, 6'b000000};
    vecs[5]  = '{1'b1, 8'h55, 1'b0, 8'h00, 4'd5, 6'b000000};
    vecs[6]  = '{1'b1, 8'h66, 1'b0, 8'h00, 4'd6, 6'b001000};
    vecs[7]  = '{1'b1, 8'h77, 1'b0, 8'h00, 4'd7, 6'b001000};
    vecs[8]  = '{1'b1, 8'h88, 1'b0, 8'h00, 4'd8, 6'b101000};
    vecs[9]  = '{1'b1, 8'h99, 1'b0, 8'h00, 4'd8, 6'b101010};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 8'h11, 4'd7, 6'b001000};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 8'h22, 4'd6, 6'b001000};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 8'h33, 4'd5, 6'b000000};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 8'h44, 4'd4, 6'b000000};
    vecs[14] = '{1'b0, 8'h00, 1'b1, 8'h55, 4'd3, 6'b000000};
    vecs[15] = '{1'b0, 8'h00, 1'b1, 8'h66, 4'd2, 6'b000100};
    vecs[16] = '{1'b0, 8'h00, 1'b1, 8'h77, 4'd1, 6'b000100};
    vecs[17] = '{1'b0, 8'h00, 1'b1, 8'h88, 4'd0, 6'b010100};
    vecs[18] = '{1'b0, 8'h00, 1'b1, 8'h88, 4'd0, 6'b010101};
    vecs[19] = '{1'b0, 8'h00, 1'b0, 8'h88, 4'd0, 6'b010100};

    doReset();
    checkOutput("reset_wrGray", 32'(wrPtrGray), 32'h0);
    checkOutput("reset_rdGray", 32'(rdPtrGray), 32'h0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 20; i++) begin
      wrEn   = vecs[i].wr;
      wrData = vecs[i].data;
      rdEn   = vecs[i].rd;
      @(posedge clk);
      #1;
      wrEn = 1'b0;
      rdEn = 1'b0;
      checkOutput($sformatf("vec%0d_rdData", i), 32'(rdData), 32'(vecs[i].exp_rd));
      checkOutput($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_cnt));
      checkOutput($sformatf("vec%0d_flags", i), 32'(flagsNow()), 32'(vecs[i].exp_flags));
    end

    exp_q.delete();
    m_wr   = 8;
    m_rd   = 8;
    m_data = 8'h88;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;

    // Hold occupancy at 4 while both pointers run through the 15->0 wrap.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'(8'hD0 + i), 1'b1);
      checkOutput("simul_count4", 32'(count), 32'd4);
    end
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)));
    end

    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'h60 + i), 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("pre_reset_count", 32'(count), 32'd5);
    wrEn   = 1'b1;
    wrData = 8'hEE;
    #3 rstN = 1'b0;
    #1;
    checkOutput("async_rdData", 32'(rdData), 32'h0);
    checkOutput("async_count", 32'(count), 32'h0);
    checkOutput("async_flags", 32'(flagsNow()), 32'(6'b010100));
    checkOutput("async_wrGray", 32'(wrPtrGray), 32'h0);
    checkOutput("async_rdGray", 32'(rdPtrGray), 32'h0);
    wrEn = 1'b0;
    @(posedge clk);
    #1 rstN = 1'b1;
    modelReset();
    applyStimulus(1'b1, 8'hA5, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("after_reset_rdData", 32'(rdData), 32'hA5);

    applyStimulus(1'b1, 8'h3C, 1'b1);
    checkOutput("simul_empty_count", 32'(count), 32'd1);
    checkOutput("simul_empty_udf", 32'(underflow), 32'd1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0);
    checkOutput("refill_full", 32'(full), 32'd1);
    applyStimulus(1'b1, 8'h5A, 1'b1);
    checkOutput("simul_full_count", 32'(count), 32'd7);
    checkOutput("simul_full_ovf", 32'(overflow), 32'd1);
    checkOutput("simul_full_rdData", 32'(rdData), 32'h3C);
    applyStimulus(1'b0, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gc_sync_fifo.md
Name: gc_sync_fifo

Overview:
Parametrised single-clock FIFO with Gray-coded read/write pointers. It generalises the fixed 3-bit Gray pointer/counter block into a full data buffer with configurable width and depth.
- Write/read handshakes, full/empty/almost flags, occupancy count and error pulses.
- Gray pointers are exported so a later dual-clock variant can reuse the same pointer logic unchanged.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 3, address width; depth = 2**ADDR_W (8)
AFULL_TH, 6, almostFull asserted when count >= AFULL_TH (1..2**ADDR_W)
AEMPTY_TH, 2, almostEmpty asserted when count <= AEMPTY_TH (0..2**ADDR_W-1)

Ports:
clk  in  1  system clock, rising edge
rstN  in  1  asynchronous active-low reset
wrEn  in  1  write request
wrData  in  DATA_W  write data
rdEn  in  1  read request
rdData  out  DATA_W  registered read data
full  out  1  FIFO holds 2**ADDR_W words
empty  out  1  FIFO holds 0 words
almostFull  out  1  count >= AFULL_TH
almostEmpty  out  1  count <= AEMPTY_TH
count  out  ADDR_W+1  current occupancy, 0..2**ADDR_W
overflow  out  1  one-cycle pulse: write rejected
underflow  out  1  one-cycle pulse: read rejected
wrPtrGray  out  ADDR_W+1  Gray-coded write pointer
rdPtrGray  out  ADDR_W+1  Gray-coded read pointer

Behaviour:
- Reset (rstN low, asynchronous, any time):
  - Pointers = 0, rdData = 0, count = 0.
  - empty = 1, almostEmpty = 1, full = 0, almostFull = 0, overflow = 0, underflow = 0.
  - Memory contents are not reset.
- Pointers: binary wrBin/rdBin, ADDR_W+1 bits, wrapping modulo 2**(ADDR_W+1). Memory address = low ADDR_W bits.
  - Gray = bin ^ (bin >> 1), registered.
  - Exactly one Gray bit changes per increment, including at wrap.
- Write accepted (wrAcc = wrEn & ~full): mem[wrBin] <= wrData; wrBin increments at the same edge.
- Read accepted (rdAcc = rdEn & ~empty): rdData <= mem[rdBin]; rdBin increments.
  - Read latency 1 clock: data is valid after the edge that accepts rdEn.
  - rdData holds its last value when no read is accepted.
- Flags use registered state from before the edge:
  - A write while full is rejected even if a read is accepted in the same cycle.
  - A read while empty is rejected even if a write is accepted in the same cycle (no fall-through).
- Simultaneous accepted read and write when neither full nor empty: count unchanged; the read returns the oldest word.
- full: wrPtrGray and rdPtrGray differ in the top two bits and match in all remaining bits.
- empty: wrPtrGray == rdPtrGray.
- count = wrBin - rdBin (ADDR_W+1 bits, modulo). full and empty are mutually exclusive.
- overflow = registered (wrEn & full); underflow = registered (rdEn & empty). Each is high for exactly the cycle after the rejected request. The rejected request has no other effect.
- Flags, count and Gray outputs all update on the same edge as the pointer change; they are registered, with no combinational path from inputs.
- Data ordering is strict FIFO across any number of pointer wraps.

Decomposition:
- Package gc_fifo_pkg holds:
  - Function bin2gray(bin) and function gray2bin(gray), the latter for the verification checker and the future dual-clock variant.
  - Constant DEPTH = 2**ADDR_W, derived locally via the parameter.
- One sub-module, gc_ptr (ADDR_W+1 bits): increment enable in; binary and Gray registers out; asynchronous active-low reset. Instantiated twice, once for write and once for read.
- Storage is an inferred register array inside gc_sync_fifo.

Test Plan:
- Reset then idle 5 cycles -> empty=1, almostEmpty=1, count=0, rdData=0, wrPtrGray=rdPtrGray=0.
- Write 0x11..0x88 (8 words) -> full=1 after 8th edge, count=8, almostFull=1 from count=6.
  - 9th write 0x99 -> overflow pulse 1 cycle, count stays 8.
- Read 8 from full -> rdData 0x11..0x88 in order, one cycle after each rdEn; empty=1 after last read.
  - Extra read -> underflow pulse, rdData holds 0x88.
- 40 random interleaved writes/reads with simultaneous wrEn&rdEn at count=4 -> count unchanged that cycle; scoreboard order matches.
  - wrPtrGray/rdPtrGray change exactly one bit per increment across the 15->0 wrap.
- rstN low mid-burst at count=5 (asynchronous, between edges) -> all outputs return to reset values immediately.
  - Subsequent write 0xA5 then read -> rdData=0xA5.
- Simultaneous wrEn&rdEn when empty -> write accepted, underflow=1, count=1. When full -> read accepted, overflow=1, count=7.
